spi_bus_arbiter: RTL

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

---
 rtl/spi_bus_arbiter_pkg.sv | 21 ++
 rtl/spi_bus_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter and the LED/button engine:
// arbiter state encoding and the levels the bus pins park at when nobody owns it.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

  localparam int AGE_W   = 16;
  localparam int GUARD_W = 4;

  localparam logic IDLE_CSN     = 1'b1;
  localparam logic IDLE_CLK     = 1'b0;
  localparam logic IDLE_CLK_OE  = 1'b1;
  localparam logic IDLE_MOSI    = 1'b0;
  localparam logic IDLE_MOSI_OE = 1'b0;

endpackage

// File: rtl/spi_bus_arbiter.sv
// Two-master SPI bus arbiter: non-preemptive ownership, guard gap between owners,
// and an age counter that lets the LED engine (m1) overtake the flash master (m0).
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int AGE_LIMIT    = 255
) (
  input  logic clk,
  input  logic rst_n,

  input  logic m0_req,
  output logic m0_gnt,
  input  logic m0_mosi_o,
  input  logic m0_mosi_oe,
  input  logic m0_clk_o,
  input  logic m0_csn_o,
  output logic m0_miso_i,

  input  logic m1_req,
  output logic m1_gnt,
  input  logic m1_mosi_o,
  input  logic m1_mosi_oe,
  input  logic m1_clk_o,
  input  logic m1_csn_o,
  output logic m1_miso_i,

  output logic bus_mosi_o,
  output logic bus_mosi_oe,
  output logic bus_clk_o,
  output logic bus_clk_oe,
  output logic bus_csn_o,
  input  logic bus_miso_i,

  output logic m1_starved
);

  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [AGE_W-1:0]   AGE_MAX    = AGE_W'(AGE_LIMIT);

  arb_state_e         state_q, state_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               starved_q, starved_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      age_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      age_q     <= age_d;
      starved_q <= starved_d;
    end
  end

  // An owner is only released once it has deasserted its request and its chip select.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = (age_q >= AGE_MAX) ? OWN1 : OWN0;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req && m0_csn_o) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      OWN1: begin
        if (!m1_req && m1_csn_o) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    age_d     = age_q;
    starved_d = 1'b0;
    if (!m1_req || state_d == OWN1) begin
      age_d = '0;
    end else if (state_q != OWN1 && age_q < AGE_MAX) begin
      age_d     = age_q + 1'b1;
      starved_d = (age_q == AGE_MAX - 1'b1);
    end
  end

  assign m0_gnt     = (state_q == OWN0);
  assign m1_gnt     = (state_q == OWN1);
  assign m1_starved = starved_q;
  assign m0_miso_i  = bus_miso_i;
  assign m1_miso_i  = bus_miso_i;

  // Pin mux follows the owner combinationally; the clock driver stays enabled throughout.
  always_comb begin
    bus_mosi_o  = IDLE_MOSI;
    bus_mosi_oe = IDLE_MOSI_OE;
    bus_clk_o   = IDLE_CLK;
    bus_clk_oe  = IDLE_CLK_OE;
    bus_csn_o   = IDLE_CSN;
    if (state_q == OWN0) begin
      bus_mosi_o  = m0_mosi_o;
      bus_mosi_oe = m0_mosi_oe;
      bus_clk_o   = m0_clk_o;
      bus_csn_o   = m0_csn_o;
    end else if (state_q == OWN1) begin
      bus_mosi_o  = m1_mosi_o;
      bus_mosi_oe = m1_mosi_oe;
      bus_clk_o   = m1_clk_o;
      bus_csn_o   = m1_csn_o;
    end
  end

endmodule
